// File: rtl/gt_link_tx.sv
// Credit-based link-layer transmitter: SYNC handshake after reset, then data forwarded
// against remote credits, with CREDIT control words returning locally freed buffer space.
module gt_link_tx #(
  parameter int unsigned GT_FIFO_SIZE = 64,
  parameter int unsigned CREDITS      = 32,
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned CREDIT_BATCH = 8,
  parameter int unsigned SYNC_MIN     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [GT_FIFO_SIZE-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [GT_FIFO_SIZE-1:0] tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic                    link_up,
  input  logic                    remote_credit_valid,
  input  logic [CNT_W-1:0]        remote_credit_count,
  input  logic                    local_free,
  output logic [CNT_W-1:0]        credits_available,
  output logic                    link_active
);

  localparam int unsigned SW = $clog2(SYNC_MIN + 1);

  localparam logic [CNT_W-1:0] L_CREDITS  = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] L_BATCH    = CNT_W'(CREDIT_BATCH);
  localparam logic [SW-1:0]    L_SYNC_MIN = SW'(SYNC_MIN);
  localparam logic [7:0]       CTRL_DEST  = 8'hFE;
  localparam logic [7:0]       TYPE_SYNC  = 8'h00;
  localparam logic [7:0]       TYPE_CRED  = 8'h01;

  localparam logic [GT_FIFO_SIZE-1:0] SYNC_WORD =
    {CTRL_DEST, TYPE_SYNC, {(GT_FIFO_SIZE-16){1'b0}}};

  typedef enum logic {StInit, StRun} state_e;

  state_e                  r_state;
  logic [GT_FIFO_SIZE-1:0] r_tx_data;
  logic                    r_tx_valid;
  logic [CNT_W-1:0]        r_credits;
  logic [CNT_W-1:0]        r_local_acc;
  logic [SW-1:0]           r_sync_cnt;

  logic                    w_run;
  logic                    w_free;
  logic                    w_can_data;
  logic                    w_sel_credit;
  logic                    w_in_ready;
  logic                    w_data_acc;
  logic                    w_sync_acc;
  logic                    w_sync_done;
  logic [CNT_W:0]          w_cred_sum;
  logic [CNT_W-1:0]        w_credits_d;
  logic [CNT_W-1:0]        w_acc_base;
  logic [CNT_W-1:0]        w_acc_d;
  logic [GT_FIFO_SIZE-1:0] w_credit_word;

  assign w_run      = (r_state == StRun);
  assign w_free     = !r_tx_valid || tx_ready;
  assign w_can_data = in_valid && (r_credits != '0);

  // A credit word goes out once a batch is ready, or early whenever data cannot use the slot.
  assign w_sel_credit = w_run && w_free &&
                        ((r_local_acc >= L_BATCH) || ((r_local_acc != '0) && !w_can_data));

  assign w_in_ready = w_run && w_free && (r_credits != '0) && !w_sel_credit;
  assign w_data_acc = in_valid && w_in_ready;

  // Counting the SYNC being accepted now lets the last one close INIT without an extra SYNC.
  assign w_sync_acc  = !w_run && r_tx_valid && tx_ready;
  assign w_sync_done = (r_sync_cnt == L_SYNC_MIN) ||
                       (w_sync_acc && (r_sync_cnt == L_SYNC_MIN - 1'b1));

  assign w_credit_word = {CTRL_DEST, TYPE_CRED, {(GT_FIFO_SIZE-16-CNT_W){1'b0}}, r_local_acc};

  always_comb begin
    w_cred_sum = {1'b0, r_credits} - {{CNT_W{1'b0}}, w_data_acc};
    if (remote_credit_valid) begin
      w_cred_sum = w_cred_sum + {1'b0, remote_credit_count};
    end
    w_credits_d = (w_cred_sum > {1'b0, L_CREDITS}) ? L_CREDITS : w_cred_sum[CNT_W-1:0];
  end

  always_comb begin
    w_acc_base = w_sel_credit ? '0 : r_local_acc;
    w_acc_d    = w_acc_base;
    if (local_free && (w_acc_base != L_CREDITS)) begin
      w_acc_d = w_acc_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StInit;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_credits   <= L_CREDITS;
      r_local_acc <= '0;
      r_sync_cnt  <= '0;
    end else begin
      r_credits   <= w_credits_d;
      r_local_acc <= w_acc_d;
      unique case (r_state)
        StInit: begin
          if (w_sync_acc && (r_sync_cnt != L_SYNC_MIN)) begin
            r_sync_cnt <= r_sync_cnt + 1'b1;
          end
          if (w_sync_done && link_up) begin
            r_state <= StRun;
            if (tx_ready) begin
              r_tx_valid <= 1'b0;
            end
          end else if (w_free) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= SYNC_WORD;
          end
        end
        StRun: begin
          if (w_sel_credit) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_credit_word;
          end else if (w_data_acc) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= in_data;
          end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  assign in_ready          = w_in_ready;
  assign tx_data           = r_tx_data;
  assign tx_valid          = r_tx_valid;
  assign credits_available = r_credits;
  assign link_active       = w_run;

endmodule
